// File: rtl/multimode_counter.sv
// multimode_counter: parametrised up/down counter with load, programmable step
// and limit, four count modes (free-run, modulo, one-shot, saturate), a
// registered terminal-count pulse and a one-shot done/busy handshake.
module multimode_counter #(
   parameter int                 WIDTH     = 8,
   parameter int                 STEP_W    = 4,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              ld,
   input  logic [WIDTH-1:0]  value,
   input  logic              dir,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  limit,
   input  logic [1:0]        mode,
   output logic [WIDTH-1:0]  count,
   output logic              tc,
   output logic              done,
   output logic              busy
);

   localparam logic [1:0] MODE_FREE = 2'b00;
   localparam logic [1:0] MODE_MOD  = 2'b01;
   localparam logic [1:0] MODE_ONE  = 2'b10;
   localparam logic [1:0] MODE_SAT  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [WIDTH-1:0]   count_next;
   logic               tc_next;

   // All arithmetic is one bit wider so carry/borrow and limit+1 are exact.
   logic [WIDTH:0]     cnt_x;
   logic [WIDTH:0]     lim_x;
   logic [WIDTH:0]     s_x;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [WIDTH:0]     lim_p1;
   logic               step_nz;
   logic               lim_zero;

   // One-shot step result, shared by IDLE and RUN.
   logic               os_hit;
   logic [WIDTH-1:0]   os_val;

   assign cnt_x    = {1'b0, count};
   assign lim_x    = {1'b0, limit};
   assign s_x      = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
   assign sum      = cnt_x + s_x;
   assign diff     = cnt_x - s_x;
   assign lim_p1   = lim_x + {{WIDTH{1'b0}}, 1'b1};
   assign step_nz  = (step != {STEP_W{1'b0}});
   assign lim_zero = (limit == {WIDTH{1'b0}});

   // Compute the one-shot step target and whether it reaches the end point.
   always_comb begin
      os_hit = 1'b0;
      os_val = count;
      if (dir) begin
         os_hit = (sum >= lim_x);
         if (os_hit) begin
            os_val = limit;
         end else begin
            os_val = sum[WIDTH-1:0];
         end
      end else begin
         os_hit = (cnt_x <= s_x);
         if (os_hit) begin
            os_val = {WIDTH{1'b0}};
         end else begin
            os_val = diff[WIDTH-1:0];
         end
      end
   end

   // Next-state and next-count logic: load beats enable; mode selects the rule.
   always_comb begin
      count_next = count;
      tc_next    = 1'b0;
      state_next = state;
      if (ld) begin
         count_next = value;
         if (mode == MODE_ONE) begin
            state_next = ST_RUN;
         end else begin
            state_next = ST_IDLE;
         end
      end else if (mode != MODE_ONE) begin
         // Leaving one-shot mode drops the FSM back to IDLE.
         state_next = ST_IDLE;
         if (en && step_nz) begin
            case (mode)
               MODE_FREE: begin
                  if (dir) begin
                     count_next = sum[WIDTH-1:0];
                     tc_next    = sum[WIDTH];
                  end else begin
                     count_next = diff[WIDTH-1:0];
                     tc_next    = diff[WIDTH];
                  end
               end
               MODE_MOD: begin
                  if (lim_zero) begin
                     count_next = {WIDTH{1'b0}};
                     tc_next    = 1'b1;
                  end else if (cnt_x > lim_x) begin
                     // Out of range (e.g. after a load): snap to the wrap point.
                     count_next = dir ? {WIDTH{1'b0}} : limit;
                     tc_next    = 1'b1;
                  end else if (dir) begin
                     if (sum > lim_x) begin
                        count_next = WIDTH'(sum - lim_p1);
                        tc_next    = 1'b1;
                     end else begin
                        count_next = sum[WIDTH-1:0];
                     end
                  end else begin
                     if (cnt_x < s_x) begin
                        count_next = WIDTH'(cnt_x + lim_p1 - s_x);
                        tc_next    = 1'b1;
                     end else begin
                        count_next = diff[WIDTH-1:0];
                     end
                  end
               end
               MODE_SAT: begin
                  // Pulse only on the edge that first lands on the clamp.
                  if (dir) begin
                     if (sum >= lim_x) begin
                        count_next = limit;
                        tc_next    = (count != limit);
                     end else begin
                        count_next = sum[WIDTH-1:0];
                     end
                  end else begin
                     if (cnt_x <= s_x) begin
                        count_next = {WIDTH{1'b0}};
                        tc_next    = (count != {WIDTH{1'b0}});
                     end else begin
                        count_next = diff[WIDTH-1:0];
                     end
                  end
               end
               default: begin
                  count_next = count;
               end
            endcase
         end else begin
            count_next = count;
         end
      end else begin
         case (state)
            ST_IDLE, ST_RUN: begin
               if (en) begin
                  state_next = ST_RUN;
                  if (step_nz) begin
                     count_next = os_val;
                     if (os_hit) begin
                        tc_next    = 1'b1;
                        state_next = ST_DONE;
                     end else begin
                        tc_next    = 1'b0;
                     end
                  end else begin
                     count_next = count;
                  end
               end else begin
                  state_next = state;
               end
            end
            ST_DONE: begin
               state_next = ST_DONE;
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // Register count, pulse, FSM state and handshake flags; reset is synchronous.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= RESET_VAL;
         tc    <= 1'b0;
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         count <= count_next;
         tc    <= tc_next;
         state <= state_next;
         busy  <= (state_next == ST_RUN);
         done  <= (state_next == ST_DONE);
      end
   end

endmodule

// File: tb/tb_multimode_counter.sv
// Directed self-checking bench for multimode_counter with hand-computed values.
module tb_multimode_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       ld;
   logic [7:0] value;
   logic       dir;
   logic [3:0] step;
   logic [7:0] limit;
   logic [1:0] mode;
   logic [7:0] count;
   logic       tc;
   logic       done;
   logic       busy;

   int checks = 0;
   int errors = 0;

   multimode_counter #(.WIDTH(8), .STEP_W(4), .RESET_VAL(8'h00)) dut (
      .clk(clk), .rst(rst), .en(en), .ld(ld), .value(value), .dir(dir),
      .step(step), .limit(limit), .mode(mode), .count(count), .tc(tc),
      .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle before sampling.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] v);
      ld = 1'b1; en = 1'b0; value = v;
      tick();
      ld = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0; en = 1'b0; ld = 1'b0; value = 8'h00; dir = 1'b1;
      step = 4'd1; limit = 8'h00; mode = 2'b00;
      tick(); tick();
      rst = 1'b1;
      load(8'h37);
      checks++; if (count !== 8'h37) begin errors++; $display("FAIL reset_preload count=%h exp=37", count); end
      rst = 1'b0; en = 1'b1;
      tick();
      checks++; if (count !== 8'h00) begin errors++; $display("FAIL reset_count count=%h exp=00", count); end
      checks++; if ({tc, done, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags tc/done/busy=%b exp=000", {tc, done, busy}); end
      // ld while in reset: reset wins
      ld = 1'b1; value = 8'hAA;
      tick();
      checks++; if (count !== 8'h00) begin errors++; $display("FAIL reset_over_ld count=%h exp=00", count); end
      ld = 1'b0; en = 1'b0; rst = 1'b1;
   endtask

   task automatic test_freerun;
      mode = 2'b00; dir = 1'b1; step = 4'd1;
      load(8'hFE);
      en = 1'b1;
      tick();
      checks++; if ({count, tc} !== {8'hFF, 1'b0}) begin errors++; $display("FAIL free_up1 count=%h tc=%b exp=FF/0", count, tc); end
      tick();
      checks++; if ({count, tc} !== {8'h00, 1'b1}) begin errors++; $display("FAIL free_carry count=%h tc=%b exp=00/1", count, tc); end
      tick();
      checks++; if ({count, tc} !== {8'h01, 1'b0}) begin errors++; $display("FAIL free_up3 count=%h tc=%b exp=01/0", count, tc); end
      dir = 1'b0;
      tick();
      checks++; if ({count, tc} !== {8'h00, 1'b0}) begin errors++; $display("FAIL free_dn1 count=%h tc=%b exp=00/0", count, tc); end
      tick();
      checks++; if ({count, tc} !== {8'hFF, 1'b1}) begin errors++; $display("FAIL free_borrow count=%h tc=%b exp=FF/1", count, tc); end
      en = 1'b0;
   endtask

   task automatic test_modulo;
      mode = 2'b01; limit = 8'd9; step = 4'd3; dir = 1'b1;
      load(8'd7);
      en = 1'b1;
      tick();
      checks++; if ({count, tc} !== {8'd0, 1'b1}) begin errors++; $display("FAIL mod_wrap_up count=%0d tc=%b exp=0/1", count, tc); end
      tick();
      checks++; if ({count, tc} !== {8'd3, 1'b0}) begin errors++; $display("FAIL mod_up count=%0d tc=%b exp=3/0", count, tc); end
      load(8'd1);
      dir = 1'b0; en = 1'b1;
      tick();
      checks++; if ({count, tc} !== {8'd8, 1'b1}) begin errors++; $display("FAIL mod_wrap_dn count=%0d tc=%b exp=8/1", count, tc); end
      load(8'd20);
      dir = 1'b1; en = 1'b1;
      tick();
      checks++; if ({count, tc} !== {8'd0, 1'b1}) begin errors++; $display("FAIL mod_over_up count=%0d tc=%b exp=0/1", count, tc); end
      load(8'd20);
      dir = 1'b0; en = 1'b1;
      tick();
      checks++; if ({count, tc} !== {8'd9, 1'b1}) begin errors++; $display("FAIL mod_over_dn count=%0d tc=%b exp=9/1", count, tc); end
      limit = 8'd0; dir = 1'b1;
      load(8'd0);
      en = 1'b1;
      tick();
      checks++; if ({count, tc} !== {8'd0, 1'b1}) begin errors++; $display("FAIL mod_lim0_a count=%0d tc=%b exp=0/1", count, tc); end
      tick();
      checks++; if ({count, tc} !== {8'd0, 1'b1}) begin errors++; $display("FAIL mod_lim0_b count=%0d tc=%b exp=0/1", count, tc); end
      en = 1'b0;
   endtask

   task automatic test_oneshot;
      mode = 2'b10; limit = 8'd5; step = 4'd2; dir = 1'b1;
      load(8'd2);
      checks++; if ({count, busy, done} !== {8'd2, 1'b1, 1'b0}) begin errors++; $display("FAIL os_load count=%0d busy=%b done=%b exp=2/1/0", count, busy, done); end
      en = 1'b1;
      tick();
      checks++; if ({count, tc, busy} !== {8'd4, 1'b0, 1'b1}) begin errors++; $display("FAIL os_step count=%0d tc=%b busy=%b exp=4/0/1", count, tc, busy); end
      tick();
      checks++; if ({count, tc, done, busy} !== {8'd5, 1'b1, 1'b1, 1'b0}) begin errors++; $display("FAIL os_end count=%0d tc=%b done=%b busy=%b exp=5/1/1/0", count, tc, done, busy); end
      tick();
      checks++; if ({count, tc, done} !== {8'd5, 1'b0, 1'b1}) begin errors++; $display("FAIL os_frozen count=%0d tc=%b done=%b exp=5/0/1", count, tc, done); end
      load(8'd1);
      checks++; if ({count, done, busy} !== {8'd1, 1'b0, 1'b1}) begin errors++; $display("FAIL os_reload count=%0d done=%b busy=%b exp=1/0/1", count, done, busy); end
      mode = 2'b00;
      tick();
      checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL os_mode_exit done/busy=%b exp=00", {done, busy}); end
      mode = 2'b10; en = 1'b1;
      tick();
      checks++; if ({count, busy} !== {8'd3, 1'b1}) begin errors++; $display("FAIL os_idle_start count=%0d busy=%b exp=3/1", count, busy); end
      en = 1'b0;
   endtask

   task automatic test_saturate;
      mode = 2'b11; limit = 8'd50; step = 4'd4; dir = 1'b0;
      load(8'd6);
      en = 1'b1;
      tick();
      checks++; if ({count, tc} !== {8'd2, 1'b0}) begin errors++; $display("FAIL sat_dn count=%0d tc=%b exp=2/0", count, tc); end
      tick();
      checks++; if ({count, tc} !== {8'd0, 1'b1}) begin errors++; $display("FAIL sat_clamp0 count=%0d tc=%b exp=0/1", count, tc); end
      tick();
      checks++; if ({count, tc} !== {8'd0, 1'b0}) begin errors++; $display("FAIL sat_hold0 count=%0d tc=%b exp=0/0", count, tc); end
      ld = 1'b1; value = 8'h11; en = 1'b1;
      tick();
      ld = 1'b0;
      checks++; if ({count, tc} !== {8'h11, 1'b0}) begin errors++; $display("FAIL sat_ld_wins count=%h tc=%b exp=11/0", count, tc); end
      limit = 8'h13; dir = 1'b1;
      tick();
      checks++; if ({count, tc} !== {8'h13, 1'b1}) begin errors++; $display("FAIL sat_clamp_up count=%h tc=%b exp=13/1", count, tc); end
      tick();
      checks++; if ({count, tc} !== {8'h13, 1'b0}) begin errors++; $display("FAIL sat_hold_up count=%h tc=%b exp=13/0", count, tc); end
      en = 1'b0;
   endtask

   task automatic test_hold;
      mode = 2'b00; dir = 1'b1; step = 4'd1;
      load(8'hFF);
      step = 4'd0; en = 1'b1;
      tick();
      checks++; if ({count, tc} !== {8'hFF, 1'b0}) begin errors++; $display("FAIL step0_hold count=%h tc=%b exp=FF/0", count, tc); end
      step = 4'd1; en = 1'b0;
      tick();
      checks++; if ({count, tc} !== {8'hFF, 1'b0}) begin errors++; $display("FAIL en0_hold count=%h tc=%b exp=FF/0", count, tc); end
   endtask

   initial begin
      test_reset();
      test_freerun();
      test_modulo();
      test_oneshot();
      test_saturate();
      test_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
